// File: rtl/coco_bus_pkg.sv
// Shared types and constants for the CoCo cartridge bus front end of the 6551 ACIA wrapper.
`timescale 1ns/1ps
package coco_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_STROBE,
        READ,
        HOLD
    } bus_state_t;

    localparam logic [15:0] ACIA_BASE = 16'hFF68;
    localparam logic [15:0] ACIA_MASK = 16'hFFFC;

    localparam logic [1:0] DATA   = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] CMD    = 2'd2;
    localparam logic [1:0] CTRL   = 2'd3;

    function automatic logic addr_hit(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/coco_bus_if_sync2.sv
// Parameterised-width two-flop synchroniser with a selectable reset value.
`timescale 1ns/1ps
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg[gi] <= RESET_VAL[gi];
                    sync_reg[gi] <= RESET_VAL[gi];
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/coco_bus_if.sv
// Bridges the asynchronous CoCo E-clock bus onto the wrapper's single-clock bus:
// one-cycle write strobe per CPU write, ce held through reads with registered read-back.
`timescale 1ns/1ps
module coco_bus_if
    import coco_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ACIA_BASE,
    parameter logic [15:0] ADDR_MASK = ACIA_MASK,
    parameter int          WR_DELAY  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        coco_e,
    input  logic        coco_r_w,
    input  logic [15:0] coco_addr,
    input  logic [7:0]  coco_data_in,
    output logic [7:0]  coco_data_out,
    output logic        coco_data_oe,
    output logic        bus_ce,
    output logic        bus_r_w,
    output logic [1:0]  bus_address,
    output logic [7:0]  bus_data,
    input  logic [7:0]  bus_data_rd
);

    localparam logic [3:0] WR_DELAY_CNT = 4'(WR_DELAY);

    bus_state_t  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        e_sync;
    logic        e_prev_reg;
    logic        e_rise, e_fall;
    logic        hit;
    logic        wr_sample;
    logic        bus_r_w_reg;
    logic [1:0]  bus_address_reg;
    logic [7:0]  bus_data_reg;
    logic [7:0]  data_out_reg;
    logic        data_oe_reg;

    // E resets "high" so that a reset taken while E is high cannot fake a rising edge on release.
    sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_e_sync (
        .clock (clock),
        .reset (reset),
        .d     (coco_e),
        .q     (e_sync)
    );

    assign e_rise = e_sync & ~e_prev_reg;
    assign e_fall = ~e_sync & e_prev_reg;
    assign hit    = addr_hit(coco_addr, BASE_ADDR, ADDR_MASK);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_sample  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (e_rise && hit) begin
                    state_next = coco_r_w ? READ : WR_WAIT;
                    cnt_next   = 4'd1;
                end
            end
            WR_WAIT: begin
                // A falling E on the sampling cycle still aborts: data is only trusted while E is high.
                if (e_fall) begin
                    state_next = IDLE;
                end else if (cnt_reg == WR_DELAY_CNT) begin
                    wr_sample  = 1'b1;
                    state_next = WR_STROBE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            WR_STROBE: state_next = e_fall ? IDLE : HOLD;
            READ:      if (e_fall) state_next = IDLE;
            HOLD:      if (e_fall) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            e_prev_reg      <= 1'b1;
            bus_r_w_reg     <= 1'b1;
            bus_address_reg <= 2'd0;
            bus_data_reg    <= 8'd0;
            data_out_reg    <= 8'd0;
            data_oe_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            e_prev_reg <= e_sync;
            if (state_reg == IDLE && e_rise) begin
                bus_r_w_reg     <= coco_r_w;
                bus_address_reg <= coco_addr[1:0];
            end
            if (wr_sample) begin
                bus_data_reg <= coco_data_in;
            end
            if (state_reg == READ) begin
                data_out_reg <= bus_data_rd;
            end
            // Drive the CPU bus only once read data has had a clock to settle.
            data_oe_reg <= (state_reg == READ) && (state_next == READ);
        end
    end

    assign bus_ce        = (state_reg == WR_STROBE) || (state_reg == READ);
    assign bus_r_w       = bus_r_w_reg;
    assign bus_address   = bus_address_reg;
    assign bus_data      = bus_data_reg;
    assign coco_data_out = data_out_reg;
    assign coco_data_oe  = data_oe_reg;

endmodule

// File: tb/tb_coco_bus_if.sv
// Randomised self-checking bench for coco_bus_if against a cycle-window reference model.
`timescale 1ns/1ps
module tb_coco_bus_if;

    localparam int WR_DELAY = 8;
    // Sample index (posedges after E is driven high) at which the synchronised rising edge is seen.
    localparam int T_K = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        coco_e;
    logic        coco_r_w;
    logic [15:0] coco_addr;
    logic [7:0]  coco_data_in;
    logic [7:0]  coco_data_out;
    logic        coco_data_oe;
    logic        bus_ce;
    logic        bus_r_w;
    logic [1:0]  bus_address;
    logic [7:0]  bus_data;
    logic [7:0]  bus_data_rd;

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  model_bus_data = 8'h00;

    coco_bus_if #(.BASE_ADDR(16'hFF68), .ADDR_MASK(16'hFFFC), .WR_DELAY(WR_DELAY)) dut (
        .clock         (clock),
        .reset         (reset),
        .coco_e        (coco_e),
        .coco_r_w      (coco_r_w),
        .coco_addr     (coco_addr),
        .coco_data_in  (coco_data_in),
        .coco_data_out (coco_data_out),
        .coco_data_oe  (coco_data_oe),
        .bus_ce        (bus_ce),
        .bus_r_w       (bus_r_w),
        .bus_address   (bus_address),
        .bus_data      (bus_data),
        .bus_data_rd   (bus_data_rd)
    );

    always #5 clock = ~clock;

    // One complete E cycle: E high for hi clocks, then low for lo clocks, checked cycle by cycle.
    task automatic run_and_check(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                                 input logic [7:0] rdval, input int hi, input int lo);
        logic hit, wr_done, exp_ce, exp_oe;
        int   fall_k, ce_cnt;
        hit     = ((addr & 16'hFFFC) == 16'hFF68);
        fall_k  = hi + 1;
        wr_done = hit && !rw && (fall_k > T_K + WR_DELAY);
        ce_cnt  = 0;
        @(negedge clock);
        coco_addr    = addr;
        coco_r_w     = rw;
        coco_data_in = wdata;
        bus_data_rd  = rdval;
        for (int k = 0; k < hi + lo; k++) begin
            coco_e = (k < hi);
            @(posedge clock);
            #1;
            exp_ce = hit && (rw ? (k >= T_K + 1 && k <= fall_k) : (wr_done && k == T_K + WR_DELAY + 1));
            exp_oe = hit && rw && (k >= T_K + 2) && (k <= fall_k);
            if (bus_ce) ce_cnt++;
            checks++;
            if (bus_ce !== exp_ce) $display("FAIL bus_ce addr=%h rw=%0b k=%0d got=%b exp=%b", addr, rw, k, bus_ce, exp_ce);
            else passes++;
            checks++;
            if (coco_data_oe !== exp_oe) $display("FAIL coco_data_oe addr=%h rw=%0b k=%0d got=%b exp=%b", addr, rw, k, coco_data_oe, exp_oe);
            else passes++;
            if (exp_oe) begin
                checks++;
                if (coco_data_out !== rdval) $display("FAIL coco_data_out addr=%h k=%0d got=%h exp=%h", addr, k, coco_data_out, rdval);
                else passes++;
            end
            if (exp_ce && !rw) begin
                checks++;
                if (bus_data !== wdata || bus_address !== addr[1:0] || bus_r_w !== 1'b0)
                    $display("FAIL strobe addr=%h k=%0d got data=%h sel=%0d rw=%b exp data=%h sel=%0d rw=0",
                             addr, k, bus_data, bus_address, bus_r_w, wdata, addr[1:0]);
                else passes++;
            end
            if (hit && k >= T_K + 1) begin
                checks++;
                if (bus_r_w !== rw || bus_address !== addr[1:0])
                    $display("FAIL latch addr=%h k=%0d got rw=%b sel=%0d exp rw=%b sel=%0d", addr, k, bus_r_w, bus_address, rw, addr[1:0]);
                else passes++;
            end
            @(negedge clock);
        end
        if (wr_done) model_bus_data = wdata;
        checks++;
        if (bus_data !== model_bus_data) $display("FAIL bus_data_after addr=%h rw=%0b got=%h exp=%h", addr, rw, bus_data, model_bus_data);
        else passes++;
        $display("txn addr=%h rw=%0b wdata=%h rdval=%h hi=%0d lo=%0d hit=%0b ce_cycles=%0d",
                 addr, rw, wdata, rdval, hi, lo, hit, ce_cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1; coco_e = 1'b0; coco_r_w = 1'b1; coco_addr = 16'h0000;
        coco_data_in = 8'h00; bus_data_rd = 8'h00;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (bus_ce !== 1'b0 || coco_data_oe !== 1'b0 || bus_r_w !== 1'b1 || bus_address !== 2'd0 ||
            bus_data !== 8'h00 || coco_data_out !== 8'h00)
            $display("FAIL reset_values got ce=%b oe=%b rw=%b sel=%0d data=%h out=%h exp ce=0 oe=0 rw=1 sel=0 data=00 out=00",
                     bus_ce, coco_data_oe, bus_r_w, bus_address, bus_data, coco_data_out);
        else passes++;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        model_bus_data = 8'h00;
        $display("txn reset");
    endtask

    task automatic test_write();
        run_and_check(16'hFF6A, 1'b0, 8'h0B, 8'hEE, 32, 32);
    endtask

    task automatic test_read();
        run_and_check(16'hFF69, 1'b1, 8'h77, 8'h10, 32, 32);
    endtask

    task automatic test_miss();
        run_and_check(16'hFF6C, 1'b1, 8'h11, 8'h22, 32, 32);
        run_and_check(16'hFF6C, 1'b0, 8'h33, 8'h44, 32, 32);
        run_and_check(16'hFF67, 1'b1, 8'h55, 8'h66, 32, 32);
        run_and_check(16'hFF67, 1'b0, 8'h77, 8'h88, 32, 32);
    endtask

    task automatic test_short_write();
        run_and_check(16'hFF68, 1'b0, 8'hC3, 8'h00, 6, 26);
        // A normal access right after the abort shows the interface returned to idle.
        run_and_check(16'hFF6B, 1'b1, 8'h00, 8'h5A, 32, 32);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals = '{8'h55, 8'hAA, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) run_and_check(16'hFF69, 1'b0, vals[i], 8'h00, 32, 32);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        coco_addr = 16'hFF69; coco_r_w = 1'b1; bus_data_rd = 8'h3C; coco_e = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (bus_ce !== 1'b1 || coco_data_oe !== 1'b1) $display("FAIL pre_reset_read got ce=%b oe=%b exp ce=1 oe=1", bus_ce, coco_data_oe);
        else passes++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (bus_ce !== 1'b0 || coco_data_oe !== 1'b0 || bus_r_w !== 1'b1 || bus_address !== 2'd0 ||
            bus_data !== 8'h00 || coco_data_out !== 8'h00)
            $display("FAIL mid_read_reset got ce=%b oe=%b rw=%b sel=%0d data=%h out=%h exp ce=0 oe=0 rw=1 sel=0 data=00 out=00",
                     bus_ce, coco_data_oe, bus_r_w, bus_address, bus_data, coco_data_out);
        else passes++;
        model_bus_data = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            coco_e = (k < 4);
            @(posedge clock);
            #1;
            checks++;
            if (bus_ce !== 1'b0 || coco_data_oe !== 1'b0) $display("FAIL post_reset_quiet k=%0d got ce=%b oe=%b exp ce=0 oe=0", k, bus_ce, coco_data_oe);
            else passes++;
            @(negedge clock);
        end
        $display("txn reset_mid_read");
        run_and_check(16'hFF6B, 1'b1, 8'h00, 8'hA5, 32, 32);
    endtask

    task automatic test_random();
        logic [15:0] addr;
        int          hi;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = 16'hFF68 | 16'($urandom_range(0, 3));
                2:       addr = ($urandom_range(0, 1) != 0) ? 16'hFF6C : 16'hFF67;
                default: addr = 16'($urandom);
            endcase
            hi = ($urandom_range(0, 2) != 0) ? int'($urandom_range(10, 32)) : int'($urandom_range(4, 7));
            run_and_check(addr, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), hi, int'($urandom_range(4, 32)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_miss();
        test_short_write();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
